mem_port_arbiter: RTL

- Shares the single external memory bus between the fetch stage (instruction port) and the execute stage (data port: load, store, fload, fstore, fence).
- Grants one requester at a time and registers the granted request onto the bus.
- Returns the bus response to the granted requester only, as that port's mem_ready/mem_rdata.
- Sits between the fetch/execute stages and the memory/bus interface; one transaction outstanding at any time.

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and execute memory ports onto a single external bus, one transaction at a time.
// Optional macro MEM_ARB_ROUND_ROBIN_EN swaps fixed data-first priority for last-grant alternation.
module mem_port_arbiter #(
   parameter int XLEN = 32,
   parameter int STRB = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            imem_valid,
   input  logic [XLEN-1:0] imem_addr,
   output logic            imem_ready,
   output logic [XLEN-1:0] imem_rdata,
   input  logic            dmem_valid,
   input  logic [XLEN-1:0] dmem_addr,
   input  logic [XLEN-1:0] dmem_wdata,
   input  logic [STRB-1:0] dmem_wstrb,
   output logic            dmem_ready,
   output logic [XLEN-1:0] dmem_rdata,
   output logic            bus_valid,
   output logic            bus_instr,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [STRB-1:0] bus_wstrb,
   input  logic            bus_ready,
   input  logic [XLEN-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t state;
   logic   grant_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_instr;

   // On contention the port that did not win last time goes first.
   always_comb begin
      grant_data = dmem_valid && (!imem_valid || last_instr);
   end
`else
   always_comb begin
      grant_data = dmem_valid;
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bus_valid <= 1'b0;
         bus_instr <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_instr <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_data) begin
                  bus_valid <= 1'b1;
                  bus_instr <= 1'b0;
                  bus_addr  <= dmem_addr;
                  bus_wdata <= dmem_wdata;
                  bus_wstrb <= dmem_wstrb;
                  state     <= BUSY_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_instr <= 1'b0;
`endif
               end else if (imem_valid) begin
                  bus_valid <= 1'b1;
                  bus_instr <= 1'b1;
                  bus_addr  <= imem_addr;
                  bus_wdata <= '0;
                  bus_wstrb <= '0;
                  state     <= BUSY_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_instr <= 1'b1;
`endif
               end
            end
            BUSY_I, BUSY_D: begin
               // Captured fields hold until completion; requester changes never reach the bus.
               if (bus_ready) begin
                  bus_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               bus_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // A requester that dropped valid mid-transaction has abandoned it, so its response is discarded.
   assign imem_ready = (state == BUSY_I) && bus_ready && imem_valid;
   assign dmem_ready = (state == BUSY_D) && bus_ready && dmem_valid;
   assign imem_rdata = imem_ready ? bus_rdata : '0;
   assign dmem_rdata = dmem_ready ? bus_rdata : '0;

endmodule
